// File: rtl/sa_pkg.sv
// Shared FSM state type and sizing helpers for the weight-stationary systolic array.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sa_state_t;

  // Accept-to-output latency: skew/compute wavefront plus input and output registers.
  function automatic int sa_lat(input int rows, input int cols);
    return rows + cols;
  endfunction

  function automatic int sa_acc_w(input int dw, input int rows);
    return 2 * dw + $clog2(rows);
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Processing element: holds one weight, forwards X right and the partial sum down.
module sa_pe #(
  parameter int DW = 16,
  parameter int AW = 35
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_load,
  input  logic [DW-1:0] w_in,
  input  logic [DW-1:0] x_in,
  input  logic [AW-1:0] psum_in,
  output logic [DW-1:0] x_out,
  output logic [AW-1:0] psum_out
);

  logic [DW-1:0]          w_q;
  logic signed [2*DW-1:0] x_ext;
  logic signed [2*DW-1:0] w_ext;
  logic signed [2*DW-1:0] prod;

  assign x_ext = {{DW{x_in[DW-1]}}, x_in};
  assign w_ext = {{DW{w_q[DW-1]}}, w_q};
  assign prod  = x_ext * w_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q      <= '0;
      x_out    <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) w_q <= w_in;
      x_out    <= x_in;
      psum_out <= psum_in + AW'(prod);
    end
  end

endmodule

// File: rtl/sa_ws_array.sv
// Weight-stationary ROWSxCOLS systolic matrix-vector engine, Y = X_row * W.
// Define SA_SAT_EN to saturate narrowed outputs instead of wrapping.
module sa_ws_array
  import sa_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 16,
  parameter int FW   = 13
) (
  input  logic                 I_CLK,
  input  logic                 I_RST_N,
  input  logic                 I_START,
  input  logic                 I_KEEP_W,
  input  logic                 I_W_VLD,
  input  logic [COLS*DW-1:0]   I_W_ROW,
  output logic                 O_W_RDY,
  input  logic                 I_X_VLD,
  input  logic                 I_X_LAST,
  input  logic [ROWS*DW-1:0]   I_X_ROW,
  output logic                 O_X_RDY,
  output logic                 O_Y_VLD,
  output logic [COLS*DW-1:0]   O_Y_ROW,
  output logic                 O_BUSY,
  output logic                 O_DONE
);

  // state | meaning
  // IDLE  | waiting for I_START
  // LOAD  | accepting ROWS weight rows (cnt counts down to 0)
  // RUN   | accepting X rows until one flagged last
  // DRAIN | flushing the array for LAT cycles (cnt counts down to 0)

  localparam int LAT = sa_lat(ROWS, COLS);
  localparam int AW  = sa_acc_w(DW, ROWS);
  localparam int CW  = $clog2(LAT + 1);

  sa_state_t          state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               w_acc, x_acc;
  logic [ROWS-1:0]    w_row_ld;
  logic [LAT-1:0]     vld_pipe;
  logic [ROWS*DW-1:0] x_q;
  logic [DW-1:0]      x_h    [ROWS][COLS+1];
  logic [AW-1:0]      psum_v [ROWS+1][COLS];
  logic [AW-1:0]      col_out [COLS];
  logic [COLS*DW-1:0] y_n;

  assign O_W_RDY = (state == ST_LOAD);
  assign O_X_RDY = (state == ST_RUN);
  assign O_BUSY  = (state != ST_IDLE);
  assign O_DONE  = (state == ST_DRAIN) && (cnt == '0);
  assign w_acc   = O_W_RDY & I_W_VLD;
  assign x_acc   = O_X_RDY & I_X_VLD;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (I_START) begin
          if (I_KEEP_W) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_LOAD;
            cnt_nxt   = CW'(ROWS - 1);
          end
        end
      end
      ST_LOAD: begin
        if (w_acc) begin
          if (cnt == '0) state_nxt = ST_RUN;
          else           cnt_nxt   = cnt - CW'(1);
        end
      end
      ST_RUN: begin
        if (x_acc && I_X_LAST) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = CW'(LAT - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Bubbles enter as zero rows so they contribute nothing to neighbouring slots.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      x_q      <= '0;
      vld_pipe <= '0;
      O_Y_VLD  <= 1'b0;
      O_Y_ROW  <= '0;
    end else begin
      x_q      <= x_acc ? I_X_ROW : '0;
      vld_pipe <= {vld_pipe[LAT-2:0], x_acc};
      O_Y_VLD  <= vld_pipe[LAT-1];
      O_Y_ROW  <= vld_pipe[LAT-1] ? y_n : '0;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    assign w_row_ld[r] = w_acc && (cnt == CW'(ROWS - 1 - r));
    if (r == 0) begin : g_direct
      assign x_h[r][0] = x_q[r*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] dly [r];
      always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
          for (int k = 0; k < r; k++) dly[k] <= '0;
        end else begin
          dly[0] <= x_q[r*DW +: DW];
          for (int k = 1; k < r; k++) dly[k] <= dly[k-1];
        end
      end
      assign x_h[r][0] = dly[r-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk      (I_CLK),
        .rst_n    (I_RST_N),
        .w_load   (w_row_ld[r]),
        .w_in     (I_W_ROW[c*DW +: DW]),
        .x_in     (x_h[r][c]),
        .psum_in  (psum_v[r][c]),
        .x_out    (x_h[r][c+1]),
        .psum_out (psum_v[r+1][c])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign psum_v[0][c] = '0;
    if (c == COLS - 1) begin : g_direct
      assign col_out[c] = psum_v[ROWS][c];
    end else begin : g_dly
      logic [AW-1:0] dly [COLS-1-c];
      always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
          for (int k = 0; k < COLS - 1 - c; k++) dly[k] <= '0;
        end else begin
          dly[0] <= psum_v[ROWS][c];
          for (int k = 1; k < COLS - 1 - c; k++) dly[k] <= dly[k-1];
        end
      end
      assign col_out[c] = dly[COLS-2-c];
    end

`ifdef SA_SAT_EN
    localparam logic signed [AW-FW-1:0] SMAX = {{(AW-FW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-FW-1:0] SMIN = {{(AW-FW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    logic signed [AW-FW-1:0] sh;
    assign sh = col_out[c][AW-1:FW];
    assign y_n[c*DW +: DW] = (sh > SMAX) ? SMAX[DW-1:0] :
                             (sh < SMIN) ? SMIN[DW-1:0] : sh[DW-1:0];
`else
    assign y_n[c*DW +: DW] = col_out[c][FW +: DW];
`endif
  end

endmodule

// File: tb/tb_sa_ws_array.sv
// Self-checking bench for sa_ws_array (4x4, Q2.13) against an arithmetic reference model.
module tb_sa_ws_array;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int FW   = 13;
  localparam int LAT  = ROWS + COLS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, keep_w = 1'b0, w_vld = 1'b0, x_vld = 1'b0, x_last = 1'b0;
  logic [63:0] w_row = '0, x_row = '0;
  logic        w_rdy, x_rdy, y_vld, busy, done;
  logic [63:0] y_row;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int y_cnt  = 0;
  bit w_rdy_seen = 1'b0;

  logic [15:0] w_model [ROWS][COLS];

  typedef struct {
    logic [63:0] y;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  sa_ws_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .FW(FW)) dut (
    .I_CLK    (clk),
    .I_RST_N  (rst_n),
    .I_START  (start),
    .I_KEEP_W (keep_w),
    .I_W_VLD  (w_vld),
    .I_W_ROW  (w_row),
    .O_W_RDY  (w_rdy),
    .I_X_VLD  (x_vld),
    .I_X_LAST (x_last),
    .I_X_ROW  (x_row),
    .O_X_RDY  (x_rdy),
    .O_Y_VLD  (y_vld),
    .O_Y_ROW  (y_row),
    .O_BUSY   (busy),
    .O_DONE   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Y[c] = floor(sum_r X[r]*W[r][c] / 2^FW), then narrowed to 16 bits.
  function automatic logic [63:0] model_y(input logic [63:0] xr);
    logic [63:0] y;
    longint      acc, s;
    y = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = 0;
      for (int r = 0; r < ROWS; r++)
        acc += longint'($signed(xr[r*16 +: 16])) * longint'($signed(w_model[r][c]));
      s = acc >>> FW;
`ifdef SA_SAT_EN
      if (s > 32767)       y[c*16 +: 16] = 16'h7FFF;
      else if (s < -32768) y[c*16 +: 16] = 16'h8000;
      else                 y[c*16 +: 16] = s[15:0];
`else
      y[c*16 +: 16] = s[15:0];
`endif
    end
    return y;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (w_rdy) w_rdy_seen = 1'b1;
    if (y_vld) begin
      y_cnt++;
      if (exp_q.size() == 0) begin
        check("y_vld_unexpected", 64'(y_vld), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("y_row", y_row, e.y);
        check("y_latency", 64'(edge_n), 64'(e.due));
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
      check("y_missing", 64'(y_vld), 64'd1);
      void'(exp_q.pop_front());
    end
    if (rst_n && x_rdy && x_vld)
      exp_q.push_back('{y: model_y(x_row), due: edge_n + 1 + LAT});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic kw);
    start  = 1'b1;
    keep_w = kw;
    tick();
    start  = 1'b0;
    keep_w = 1'b0;
  endtask

  task automatic load_w();
    logic [63:0] row;
    for (int k = 0; k < ROWS; k++) begin
      for (int c = 0; c < COLS; c++) row[c*16 +: 16] = w_model[k][c];
      check("w_rdy_in_load", 64'(w_rdy), 64'd1);
      w_vld = 1'b1;
      w_row = row;
      tick();
    end
    w_vld = 1'b0;
    check("x_rdy_after_load", 64'(x_rdy), 64'd1);
  endtask

  task automatic send_x(input logic [63:0] row, input logic last);
    x_vld  = 1'b1;
    x_row  = row;
    x_last = last;
    tick();
    x_vld  = 1'b0;
    x_last = 1'b0;
  endtask

  function automatic logic [63:0] rand_row();
    return {$urandom, $urandom};
  endfunction

  // Single-row job: exact latency, DONE position and result checked directly.
  task automatic run_single(input string tag, input logic [63:0] row, input logic [63:0] exp_y);
    send_x(row, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check({tag, "_vld_early"}, 64'(y_vld), 64'd0);
      check({tag, "_done_pos"}, 64'(done), 64'(i == LAT - 1));
    end
    @(negedge clk);
    check({tag, "_vld"}, 64'(y_vld), 64'd1);
    check({tag, "_y"}, y_row, exp_y);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    tick();
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * LAT && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    if (seen) begin
      start  = 1'b1;
      keep_w = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_start_at_done_ignored"}, 64'(busy), 64'd0);
      check({tag, "_no_load_after_done"}, 64'(w_rdy), 64'd0);
    end
    tick();
    tick();
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] r0;

    repeat (2) @(negedge clk);
    check("rst_w_rdy", 64'(w_rdy), 64'd0);
    check("rst_x_rdy", 64'(x_rdy), 64'd0);
    check("rst_y_vld", 64'(y_vld), 64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_y_row", y_row, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);

    // Identity weights: output reproduces X.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w_model[r][c] = (r == c) ? 16'h2000 : 16'h0000;
    start_job(1'b0);
    load_w();
    run_single("identity", 64'h4000_F800_1000_2000, 64'h4000_F800_1000_2000);

    // 1.5 * 1.5 * 4 = 9.0 exceeds Q2.13 range.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w_model[r][c] = 16'h3000;
    start_job(1'b0);
    load_w();
`ifdef SA_SAT_EN
    run_single("overflow", {4{16'h3000}}, 64'h7FFF_7FFF_7FFF_7FFF);
`else
    run_single("overflow", {4{16'h3000}}, 64'h2000_2000_2000_2000);
`endif

    // Random weights, three rows with one bubble between rows 1 and 2.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w_model[r][c] = 16'($urandom);
    start_job(1'b0);
    load_w();
    y_cnt = 0;
    send_x(rand_row(), 1'b0);
    send_x(rand_row(), 1'b0);
    tick();
    send_x(rand_row(), 1'b1);
    wait_done("bubble");
    check("bubble_y_count", 64'(y_cnt), 64'd3);

    // Reuse weights; stray start and weight traffic during RUN must be ignored.
    w_rdy_seen = 1'b0;
    start_job(1'b1);
    check("keep_w_run", 64'(x_rdy), 64'd1);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        w_vld = 1'b1;
        w_row = rand_row();
        tick();
        w_vld = 1'b0;
      end
      if (i == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy_x_rdy", 64'(x_rdy), 64'd1);
        check("start_busy_w_rdy", 64'(w_rdy), 64'd0);
      end
      send_x(rand_row(), i == 5);
    end
    wait_done("keep_w");
    check("keep_w_no_w_rdy", 64'(w_rdy_seen), 64'd0);

    // Mid-RUN reset: everything drops at once, in-flight rows vanish, weights cleared.
    start_job(1'b1);
    send_x(rand_row(), 1'b0);
    send_x(rand_row(), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w_model[r][c] = 16'h0000;
    check("midrst_x_rdy", 64'(x_rdy), 64'd0);
    check("midrst_w_rdy", 64'(w_rdy), 64'd0);
    check("midrst_busy",  64'(busy),  64'd0);
    check("midrst_y_vld", 64'(y_vld), 64'd0);
    check("midrst_done",  64'(done),  64'd0);
    check("midrst_y_row", y_row, 64'd0);
    y_cnt = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (LAT + 4) tick();
    check("midrst_no_y", 64'(y_cnt), 64'd0);

    r0 = rand_row();
    start_job(1'b1);
    send_x(r0, 1'b1);
    wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
